// File: rtl/rx_prbs_checker.sv
// rx_prbs_checker
// Bit-serial PRBS checker for the sliced receiver decision bit. The local LFSR
// self-synchronises on the incoming stream (SEED), proves itself on LOCK_CNT
// consecutive predictions (VERIFY), then free-runs (LOCKED) while the checker
// counts compared bits and bit errors for BER measurement.
// Polynomial: x^PRBS_N + x^PRBS_TAP + 1; prediction p = sr[N-1] ^ sr[TAP-1].

module rx_prbs_checker #(
    parameter int PRBS_N   = 7,
    parameter int PRBS_TAP = 6,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             data_i,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int SEED_W  = $clog2(PRBS_N + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [SEED_W-1:0]  SEED_DONE  = SEED_W'(PRBS_N);
    localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(LOCK_CNT);
    localparam logic [LOSS_W-1:0]  LOSS_DONE  = LOSS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_r;
    logic [PRBS_N-1:0]    sr_r;
    logic [SEED_W-1:0]    seed_cnt_r;
    logic [MATCH_W-1:0]   match_cnt_r;
    logic [LOSS_W-1:0]    loss_cnt_r;
    logic                 locked_r;
    logic                 err_r;
    logic [CNT_W-1:0]     bit_count_r;
    logic [CNT_W-1:0]     err_count_r;

    logic                 pred_s;
    logic                 mismatch_s;
    logic [PRBS_N-1:0]    sr_data_s;
    logic [PRBS_N-1:0]    sr_pred_s;
    logic [SEED_W-1:0]    seed_inc_s;
    logic [MATCH_W-1:0]   match_inc_s;
    logic [LOSS_W-1:0]    loss_inc_s;
    logic                 bit_sat_s;
    logic                 err_sat_s;
    logic                 count_en_s;

    // Prediction, shift candidates and incremented counts for this cycle
    always_comb begin
        pred_s      = sr_r[PRBS_N-1] ^ sr_r[PRBS_TAP-1];
        mismatch_s  = data_i ^ pred_s;
        sr_data_s   = {sr_r[PRBS_N-2:0], data_i};
        sr_pred_s   = {sr_r[PRBS_N-2:0], pred_s};
        seed_inc_s  = seed_cnt_r + SEED_W'(1);
        match_inc_s = match_cnt_r + MATCH_W'(1);
        loss_inc_s  = loss_cnt_r + LOSS_W'(1);
        bit_sat_s   = (bit_count_r == CNT_MAX);
        err_sat_s   = (err_count_r == CNT_MAX);
        count_en_s  = en && (state_r == ST_LOCKED);
    end

    // Synchronisation FSM: seed the LFSR, verify it, then free-run and watch for lock loss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_SEED;
            sr_r        <= {PRBS_N{1'b0}};
            seed_cnt_r  <= {SEED_W{1'b0}};
            match_cnt_r <= {MATCH_W{1'b0}};
            loss_cnt_r  <= {LOSS_W{1'b0}};
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
        end else if (en) begin
            err_r <= 1'b0;
            case (state_r)
                ST_SEED: begin
                    sr_r <= sr_data_s;
                    if (seed_inc_s == SEED_DONE) begin
                        seed_cnt_r <= {SEED_W{1'b0}};
                        // An all-zero seed would lock the LFSR up forever; keep seeding
                        if (sr_data_s != {PRBS_N{1'b0}}) begin
                            match_cnt_r <= {MATCH_W{1'b0}};
                            state_r     <= ST_VERIFY;
                        end
                    end else begin
                        seed_cnt_r <= seed_inc_s;
                    end
                end
                ST_VERIFY: begin
                    sr_r <= sr_data_s;
                    if (!mismatch_s) begin
                        match_cnt_r <= match_inc_s;
                        if (match_inc_s == MATCH_DONE) begin
                            loss_cnt_r <= {LOSS_W{1'b0}};
                            locked_r   <= 1'b1;
                            state_r    <= ST_LOCKED;
                        end
                    end else begin
                        // The mismatching bit already counts as the first new seed bit
                        seed_cnt_r <= SEED_W'(1);
                        state_r    <= ST_SEED;
                    end
                end
                ST_LOCKED: begin
                    // Free-running generator so a received error never corrupts the reference
                    sr_r <= sr_pred_s;
                    if (mismatch_s) begin
                        err_r <= 1'b1;
                        if (loss_inc_s == LOSS_DONE) begin
                            loss_cnt_r <= {LOSS_W{1'b0}};
                            seed_cnt_r <= {SEED_W{1'b0}};
                            locked_r   <= 1'b0;
                            state_r    <= ST_SEED;
                        end else begin
                            loss_cnt_r <= loss_inc_s;
                        end
                    end else begin
                        loss_cnt_r <= {LOSS_W{1'b0}};
                    end
                end
                default: begin
                    seed_cnt_r <= {SEED_W{1'b0}};
                    locked_r   <= 1'b0;
                    state_r    <= ST_SEED;
                end
            endcase
        end else begin
            err_r <= 1'b0;
        end
    end

    // Saturating BER counters; a clear beats a same-cycle increment and ignores en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count_r <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            bit_count_r <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
        end else if (count_en_s) begin
            if (!bit_sat_s) begin
                bit_count_r <= bit_count_r + CNT_W'(1);
            end
            if (mismatch_s && !err_sat_s) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end
        end
    end

    assign locked    = locked_r;
    assign err       = err_r;
    assign bit_count = bit_count_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Directed bench for rx_prbs_checker: a default instance plus a CNT_W=8
// instance share all inputs so saturation can be observed on the narrow one.
// The stimulus PRBS7 source is b[n] = b[n-7] ^ b[n-6]; expected values are
// hand-derived lock latencies and counts.

module tb_rx_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        data_i = 1'b0;
    logic        locked, err;
    logic [31:0] bit_count, err_count;
    logic        locked8, err8;
    logic [7:0]  bit_count8, err_count8;

    int          checks = 0;
    int          failures = 0;
    int          err_seen = 0;
    logic [6:0]  gen_r = 7'h7F;

    rx_prbs_checker dut (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .data_i(data_i),
        .locked(locked), .err(err), .bit_count(bit_count), .err_count(err_count)
    );

    rx_prbs_checker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .data_i(data_i),
        .locked(locked8), .err(err8), .bit_count(bit_count8), .err_count(err_count8)
    );

    // Free-running bench clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Next bit of the reference PRBS7 stream
    task automatic gen(output logic b);
        b = gen_r[6] ^ gen_r[5];
        gen_r = {gen_r[5:0], b};
    endtask

    // One clock: drive inputs, wait for the edge, sample 1 time unit later
    task automatic tick(input logic d, input logic e, input logic c);
        data_i  = d;
        en      = e;
        clr_cnt = c;
        @(posedge clk);
        #1;
        if (err) err_seen++;
        clr_cnt = 1'b0;
    endtask

    // n valid bits of the reference stream, optionally inverted
    task automatic send(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            tick(b ^ inv, 1'b1, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic b;
        logic r;
        int   lk;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_bits", bit_count, 32'd0);
        check("rst_errs", err_count, 32'd0);
        rst = 1'b0;

        // Clean stream: 7 seed + 16 verify edges to lock, then 77 counted bits
        send(22, 1'b0);
        check("lock_pre23", locked, 32'd0);
        send(1, 1'b0);
        check("lock_at23", locked, 32'd1);
        send(77, 1'b0);
        check("clean_bits", bit_count, 32'd77);
        check("clean_errs", err_count, 32'd0);
        check("clean_err_pulses", err_seen, 32'd0);
        check("clean_bits8", bit_count8, 32'd77);

        // Single flipped bit, then a burst of 7 (one short of lock loss)
        send(1, 1'b1);
        check("flip1_err", err, 32'd1);
        check("flip1_errs", err_count, 32'd1);
        check("flip1_locked", locked, 32'd1);
        send(1, 1'b0);
        check("flip1_pulse_end", err, 32'd0);
        send(7, 1'b1);
        check("flip7_errs", err_count, 32'd8);
        check("flip7_pulses", err_seen, 32'd8);
        send(1, 1'b0);
        check("flip7_locked", locked, 32'd1);

        // Clear, then 8 inverted bits drop lock on the 8th (which is counted).
        // An inverted PRBS7 never satisfies the two-tap recurrence, so re-lock
        // is taken on the true stream resuming right after the burst.
        gen(b);
        tick(b, 1'b1, 1'b1);
        check("clr_bits", bit_count, 32'd0);
        send(7, 1'b1);
        check("inv7_locked", locked, 32'd1);
        send(1, 1'b1);
        check("inv8_unlocked", locked, 32'd0);
        check("inv8_errs", err_count, 32'd8);
        send(22, 1'b0);
        check("relock_pre23", locked, 32'd0);
        send(1, 1'b0);
        check("relock_at23", locked, 32'd1);
        err_seen = 0;
        send(20, 1'b0);
        check("relock_no_err", err_seen, 32'd0);
        check("relock_errs_kept", err_count, 32'd8);
        check("relock_bits", bit_count, 32'd28);

        // en low: a wrong bit is ignored; clear still works with en low
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("hold_err", err, 32'd0);
        check("hold_bits", bit_count, 32'd28);
        tick(1'b1, 1'b0, 1'b1);
        check("clr_noen_bits", bit_count, 32'd0);
        check("clr_noen_errs", err_count, 32'd0);

        // Saturation on the 8-bit instance
        send(300, 1'b0);
        check("sat_bits32", bit_count, 32'd300);
        check("sat_bits8", bit_count8, 32'd255);
        send(10, 1'b0);
        check("sat_hold8", bit_count8, 32'd255);
        check("sat_errs8", err_count8, 32'd0);

        // Clear together with a forced error: counts zero, err still pulses
        gen(b);
        tick(~b, 1'b1, 1'b1);
        check("clrerr_bits", bit_count, 32'd0);
        check("clrerr_errs", err_count, 32'd0);
        check("clrerr_bits8", bit_count8, 32'd0);
        check("clrerr_errs8", err_count8, 32'd0);
        check("clrerr_pulse", err, 32'd1);

        // Asynchronous reset while locked with nonzero counts
        send(4, 1'b0);
        gen(b);
        tick(~b, 1'b1, 1'b0);
        check("prerst_bits", bit_count, 32'd5);
        check("prerst_errs", err_count, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_locked", locked, 32'd0);
        check("midrst_err", err, 32'd0);
        check("midrst_bits", bit_count, 32'd0);
        check("midrst_errs", err_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(22, 1'b0);
        check("rstlock_pre23", locked, 32'd0);
        send(1, 1'b0);
        check("rstlock_at23", locked, 32'd1);

        // Constant zero never locks (all-zero seed rejected)
        pulse_reset();
        lk = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (locked) lk++;
        end
        check("zero_locked_cycles", lk, 32'd0);
        check("zero_bits", bit_count, 32'd0);
        check("zero_errs", err_count, 32'd0);

        // en toggled every other cycle: lock after 23 valid edges, idle cycles ignored
        pulse_reset();
        err_seen = 0;
        for (int i = 0; i < 22; i++) begin
            send(1, 1'b0);
            r = 1'($urandom);
            tick(r, 1'b0, 1'b0);
        end
        check("entog_pre23", locked, 32'd0);
        send(1, 1'b0);
        check("entog_at23", locked, 32'd1);
        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom);
            tick(r, 1'b0, 1'b0);
            send(1, 1'b0);
        end
        check("entog_bits", bit_count, 32'd20);
        check("entog_errs", err_count, 32'd0);
        check("entog_pulses", err_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
